mul: RTL and testbench

Sequential shift-add multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU). It is the companion of the sequential divider in the execute stage, and uses the same req/ready handshake so the core's M-extension sequencer drives both identically. One partial product is added per cycle, with signed handling done by magnitude conversion and a final sign adjust.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/mul_operand_prep.sv | 29 ++
 rtl/mul.sv | 128 ++++++++++++
 tb/tb_mul.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M sequential multiplier and divider:
// operation encodings, the common FSM state set and the default word width.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_CALC        = 2'd1,
        S_SIGN_ADJUST = 2'd2,
        S_DONE        = 2'd3
    } state_e;

endpackage

// File: rtl/mul_operand_prep.sv
// Combinational operand conditioning: effective operand signs, result sign
// and unsigned magnitudes for the shift-add core.
module mul_operand_prep
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [1:0]      op_i,
    output logic            neg_o,
    output logic [XLEN-1:0] a_mag_o,
    output logic [XLEN-1:0] b_mag_o
);

    logic sa;
    logic sb;

    always_comb begin
        sa      = a_i[XLEN-1] & (op_i != OP_MULHU);
        sb      = b_i[XLEN-1] & ((op_i == OP_MUL) || (op_i == OP_MULH));
        neg_o   = sa ^ sb;
        // The most negative value negates to itself, which read as unsigned is
        // exactly its magnitude.
        a_mag_o = sa ? (~a_i + 1'b1) : a_i;
        b_mag_o = sb ? (~b_i + 1'b1) : b_i;
    end

endmodule

// File: rtl/mul.sv
// Sequential shift-add multiplier for MUL/MULH/MULHSU/MULHU, one partial
// product per cycle. Define MUL_EARLY_OUT_EN to finish early on a zero operand.
module mul
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [1:0]      op_i,
    input  logic            req_i,
    output logic [XLEN-1:0] p_o,
    output logic            ready_o
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int ACC_W = 2 * XLEN + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]    b_mag_q, b_mag_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [XLEN-1:0]    p_q, p_d;
    logic               ready_q, ready_d;

    logic               neg;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;
    logic [XLEN:0]      upper;

    mul_operand_prep #(.XLEN(XLEN)) u_prep (
        .a_i     (a_i),
        .b_i     (b_i),
        .op_i    (op_i),
        .neg_o   (neg),
        .a_mag_o (a_mag),
        .b_mag_o (b_mag)
    );

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_mag_d = b_mag_q;
        op_d    = op_q;
        neg_d   = neg_q;
        p_d     = p_q;
        ready_d = 1'b0;
        upper   = acc_q[2*XLEN:XLEN];

        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    op_d    = op_i;
                    neg_d   = neg;
                    b_mag_d = b_mag;
                    acc_d   = {1'b0, {XLEN{1'b0}}, a_mag};
                    cnt_d   = CNT_W'(XLEN);
                    state_d = S_CALC;
`ifdef MUL_EARLY_OUT_EN
                    if ((a_i == '0) || (b_i == '0)) begin
                        acc_d   = '0;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                // Add into the upper half with carry into the top bit, then
                // shift the whole accumulator right to retire one multiplier bit.
                if (acc_q[0]) begin
                    upper = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_mag_q};
                end
                acc_d = {upper, acc_q[XLEN-1:0]} >> 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_SIGN_ADJUST;
                end
            end
            S_SIGN_ADJUST: begin
                if (neg_q) begin
                    acc_d[2*XLEN-1:0] = ~acc_q[2*XLEN-1:0] + 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                p_d     = (op_q == OP_MUL) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of every other flop, regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_mag_q <= '0;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            p_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_mag_q <= b_mag_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            p_q     <= p_d;
            ready_q <= ready_d;
        end
    end

    assign p_o     = p_q;
    assign ready_o = ready_q;

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: directed corner cases, handshake timing and
// randomized operations against a plain-arithmetic product model.
module tb_mul;
    import muldiv_pkg::*;

    localparam int LIMIT = 120;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [1:0]  op_i;
    logic        req_i;
    logic [31:0] p_o;
    logic        ready_o;

    int total;
    int bad;

    mul dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .a_i     (a_i),
        .b_i     (b_i),
        .op_i    (op_i),
        .req_i   (req_i),
        .p_o     (p_o),
        .ready_o (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Full 64-bit product from sign/zero-extended operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic [63:0]        pr;
        ea = (op == OP_MULHU) ? $signed({32'b0, a}) : $signed({{32{a[31]}}, a});
        eb = (op == OP_MUL || op == OP_MULH) ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
        pr = ea * eb;
        return (op == OP_MUL) ? pr[31:0] : pr[63:32];
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
        if (a == 0 || b == 0) return 2;
`endif
        return 35;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Present a request during the cycle ending at the next posedge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_i = 1'b1;
        op_i  = op;
        a_i   = a;
        b_i   = b;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        a_i   = $urandom;
        b_i   = $urandom;
        op_i  = 2'($urandom);
    endtask

    // Advance until ready_o is seen; cycle index counted from acceptance.
    task automatic wait_ready(input int start, output int cyc);
        cyc = start;
        while (!ready_o && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int          cyc;
        logic [31:0] exp;
        exp = ref_mul(op, a, b);
        @(negedge clk);
        issue(op, a, b);
        wait_ready(1, cyc);
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat(a, b)));
        check({tag, "_p"}, p_o, exp);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'b0, ready_o}, 32'd0);
        check({tag, "_hold"}, p_o, exp);
    endtask

    initial begin
        int          cyc;
        int          pulses;
        logic [31:0] a1, b1, a2, b2;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req_i = 1'b0;
        a_i   = '0;
        b_i   = '0;
        op_i  = OP_MUL;
        repeat (3) @(posedge clk);
        #1;
        check("rst_p", p_o, 32'd0);
        check("rst_ready", {31'b0, ready_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7x6", OP_MUL, 32'd7, 32'd6);
        run_op("mulh_ff", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_ff", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul_ff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh_80", OP_MULH, 32'h8000_0000, 32'h8000_0000);
        run_op("mulhsu_80", OP_MULHSU, 32'h8000_0000, 32'h8000_0000);
        run_op("mul_80", OP_MUL, 32'h8000_0000, 32'h8000_0000);
        run_op("mul_0x5", OP_MUL, 32'd0, 32'd5);
        run_op("mulh_5x0", OP_MULH, 32'hFFFF_FFFB, 32'd0);

        // Spec-literal expectations, independent of the model.
        check("lit_mulhu_ff", ref_mul(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("lit_mulhsu_80", ref_mul(OP_MULHSU, 32'h8000_0000, 32'h8000_0000), 32'hC000_0000);

        // A request mid-operation is ignored; one in the ready cycle is accepted.
        a1 = 32'd123456;
        b1 = 32'hFFFF_FFF9;
        a2 = 32'h1234_5678;
        b2 = 32'h9ABC_DEF0;
        pulses = 0;
        @(negedge clk);
        issue(OP_MULH, a1, b1);
        cyc = 1;
        while (cyc < 10) begin
            if (ready_o) pulses++;
            @(posedge clk);
            #1;
            cyc++;
        end
        req_i = 1'b1;
        op_i  = OP_MUL;
        a_i   = 32'd3;
        b_i   = 32'd3;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        cyc   = 11;
        check("ign_early", 32'(pulses), 32'd0);
        wait_ready(cyc, cyc);
        check("ign_lat", 32'(cyc), 32'd35);
        check("ign_p", p_o, ref_mul(OP_MULH, a1, b1));
        issue(OP_MULHSU, a2, b2);
        wait_ready(cyc + 1, cyc);
        check("b2b_lat", 32'(cyc), 32'd70);
        check("b2b_p", p_o, ref_mul(OP_MULHSU, a2, b2));

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        issue(OP_MULHU, 32'hDEAD_BEEF, 32'h1357_9BDF);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_mid_p", p_o, 32'd0);
        check("rst_mid_ready", {31'b0, ready_o}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) pulses++;
        end
        check("rst_mid_pulses", 32'(pulses), 32'd0);
        check("rst_mid_p_after", p_o, 32'd0);
        run_op("mulhu_post_rst", OP_MULHU, 32'h0001_0000, 32'h0001_0000);
        check("lit_post_rst", p_o, 32'h0000_0001);

        for (int i = 0; i < 40; i++) begin
            run_op("rand", 2'($urandom), pick(), pick());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
